// File: rtl/fb_pkg.sv
// Shared framebuffer write-port types: field widths, the write beat record and the scheduler states.
package fb_pkg;

    localparam int FB_ADDR_WIDTH  = 27;
    localparam int FB_COLOR_WIDTH = 16;
    localparam int FB_Z_WIDTH     = 19;

    typedef struct packed {
        logic [FB_ADDR_WIDTH-1:0]  addr;
        logic [FB_COLOR_WIDTH-1:0] color;
        logic [FB_Z_WIDTH-1:0]     depth;
    } fb_write_t;

    typedef enum logic {
        ARB,
        CLEAR
    } fb_state_t;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Requester and framebuffer write-port signals around the scheduler.
interface fb_write_scheduler_if;
    import fb_pkg::*;

    logic [1:0]                     req_valid_in;
    logic [1:0][FB_ADDR_WIDTH-1:0]  req_addr_in;
    logic [1:0][FB_COLOR_WIDTH-1:0] req_color_in;
    logic [1:0][FB_Z_WIDTH-1:0]     req_depth_in;
    logic [1:0]                     req_ready_out;

    logic                      fb_valid_out;
    logic                      fb_ready_in;
    logic [FB_ADDR_WIDTH-1:0]  fb_addr_out;
    logic [FB_COLOR_WIDTH-1:0] fb_color_out;
    logic [FB_Z_WIDTH-1:0]     fb_depth_out;
    logic                      fb_last_out;

    // master: the scheduler itself; slave: requesters plus framebuffer
    modport master (
        input  req_valid_in, req_addr_in, req_color_in, req_depth_in, fb_ready_in,
        output req_ready_out, fb_valid_out, fb_addr_out, fb_color_out, fb_depth_out, fb_last_out
    );

    modport slave (
        output req_valid_in, req_addr_in, req_color_in, req_depth_in, fb_ready_in,
        input  req_ready_out, fb_valid_out, fb_addr_out, fb_color_out, fb_depth_out, fb_last_out
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot winner, pointer moves past the winner on advance.
module rr_arbiter2 (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = '0;
        if (valid[ptr])
            grant[ptr] = 1'b1;
        else if (valid[~ptr])
            grant[~ptr] = 1'b1;
    end

    // winner 0 hands priority to 1 and vice versa
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            ptr <= 1'b0;
        else if (advance)
            ptr <= grant[0];
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Single framebuffer write port shared round-robin by two requesters, plus a full-frame clear sweep.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int HRES       = 320,
    parameter int VRES       = 180,
    parameter int Z_WIDTH    = 19,
    parameter int ADDR_WIDTH = 27
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      clear_in,
    input  logic [FB_COLOR_WIDTH-1:0] clear_color_in,
    fb_write_scheduler_if.master      bus,
    output logic [1:0]                grant_out,
    output logic                      clearing_out,
    output logic                      clear_done_out
);

    localparam int ADDR_MAX = HRES * VRES;
    localparam int CNT_W    = $clog2(ADDR_MAX);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(ADDR_MAX - 1);
    localparam logic [Z_WIDTH-1:0] Z_MAX    = '1;

    fb_state_t                 state, state_nxt;
    logic                      clear_pending;
    logic [FB_COLOR_WIDTH-1:0] clear_color;
    logic [CNT_W-1:0]          clr_cnt;
    logic [ADDR_WIDTH-1:0]     clr_addr;

    fb_write_t out_q;
    logic      out_valid;
    logic      out_last;
    logic [1:0] grant_q;

    logic       load;
    logic       clear_accept;
    logic       last_done;
    logic       arb_en;
    logic [1:0] arb_grant;
    logic [1:0] xfer;
    fb_write_t  req_sel;

    assign load         = !out_valid || bus.fb_ready_in;
    assign clear_accept = (state == ARB) && clear_in && !clear_pending;
    assign last_done    = out_valid && bus.fb_ready_in && out_last;
    assign arb_en       = !rst_in && (state == ARB) && load && !clear_pending && !clear_accept;
    assign clr_addr     = ADDR_WIDTH'(clr_cnt);

    rr_arbiter2 u_arb (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .valid   (bus.req_valid_in),
        .advance (|xfer),
        .grant   (arb_grant)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            state <= ARB;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (clear_accept) state_nxt = CLEAR;
            CLEAR:   if (last_done)    state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        xfer         = arb_en ? arb_grant : 2'b00;
        clearing_out = (state == CLEAR);
    end

    always_comb begin
        req_sel.addr  = xfer[1] ? bus.req_addr_in[1]  : bus.req_addr_in[0];
        req_sel.color = xfer[1] ? bus.req_color_in[1] : bus.req_color_in[0];
        req_sel.depth = xfer[1] ? bus.req_depth_in[1] : bus.req_depth_in[0];
    end

    // A beat still held when a clear is accepted drains first: CLEAR only issues on load.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clear_pending  <= 1'b0;
            clear_color    <= '0;
            clr_cnt        <= '0;
            out_q          <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            grant_q        <= '0;
            clear_done_out <= 1'b0;
        end else begin
            clear_done_out <= 1'b0;
            if (clear_accept) begin
                clear_pending <= 1'b1;
                clear_color   <= clear_color_in;
                clr_cnt       <= '0;
            end
            if (state == CLEAR && last_done) begin
                clear_pending  <= 1'b0;
                clear_done_out <= 1'b1;
            end
            if (load) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                grant_q   <= '0;
                if (state == ARB) begin
                    if (|xfer) begin
                        out_valid <= 1'b1;
                        out_q     <= req_sel;
                        grant_q   <= xfer;
                    end
                end else if (!last_done) begin
                    out_valid   <= 1'b1;
                    out_q.addr  <= FB_ADDR_WIDTH'(clr_addr);
                    out_q.color <= clear_color;
                    out_q.depth <= FB_Z_WIDTH'(Z_MAX);
                    out_last    <= (clr_cnt == LAST_CNT);
                    if (clr_cnt != LAST_CNT)
                        clr_cnt <= clr_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.req_ready_out = xfer;
    assign bus.fb_valid_out  = out_valid;
    assign bus.fb_addr_out   = out_q.addr;
    assign bus.fb_color_out  = out_q.color;
    assign bus.fb_depth_out  = out_q.depth;
    assign bus.fb_last_out   = out_last;
    assign grant_out         = grant_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler: arbitration table, clear sweep, and reset abort.
module tb_fb_write_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        clear_in = 1'b0;
    logic [15:0] clear_color_in = '0;
    logic [1:0]  grant_out;
    logic        clearing_out;
    logic        clear_done_out;

    int checks = 0;
    int failures = 0;

    fb_write_scheduler_if bus ();

    fb_write_scheduler #(
        .HRES       (320),
        .VRES       (180),
        .Z_WIDTH    (19),
        .ADDR_WIDTH (27)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .clear_in       (clear_in),
        .clear_color_in (clear_color_in),
        .bus            (bus),
        .grant_out      (grant_out),
        .clearing_out   (clearing_out),
        .clear_done_out (clear_done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0]  valid;
        logic [26:0] a0;
        logic [26:0] a1;
        logic        rdy;
        logic [1:0]  exp_ready;
        logic        exp_fbv;
        logic [26:0] exp_addr;
        logic [1:0]  exp_grant;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [15:0] rcolor(int i, logic [26:0] a);
        return 16'(a * 3) + 16'(i * 7 + 1);
    endfunction

    function automatic logic [18:0] rdepth(int i, logic [26:0] a);
        return 19'(a) + 19'(i * 1000 + 3);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [1:0] v, logic [26:0] a0, logic [26:0] a1, logic rdy);
        bus.req_valid_in    = v;
        bus.req_addr_in[0]  = a0;
        bus.req_addr_in[1]  = a1;
        bus.req_color_in[0] = rcolor(0, a0);
        bus.req_color_in[1] = rcolor(1, a1);
        bus.req_depth_in[0] = rdepth(0, a0);
        bus.req_depth_in[1] = rdepth(1, a1);
        bus.fb_ready_in     = rdy;
    endtask

    initial begin
        int next_exp;
        int seq_err;
        int last_cnt;
        int rdy_viol;
        int clr_viol;
        int done_cnt;
        int src;
        logic found;

        vecs[0]  = '{2'b00, 27'd0,  27'd0,  1'b1, 2'b00, 1'b0, 27'd0,  2'b00};
        vecs[1]  = '{2'b01, 27'd5,  27'd0,  1'b1, 2'b01, 1'b1, 27'd5,  2'b01};
        vecs[2]  = '{2'b11, 27'd10, 27'd20, 1'b1, 2'b10, 1'b1, 27'd20, 2'b10};
        vecs[3]  = '{2'b11, 27'd11, 27'd21, 1'b1, 2'b01, 1'b1, 27'd11, 2'b01};
        vecs[4]  = '{2'b11, 27'd12, 27'd22, 1'b1, 2'b10, 1'b1, 27'd22, 2'b10};
        vecs[5]  = '{2'b11, 27'd13, 27'd23, 1'b1, 2'b01, 1'b1, 27'd13, 2'b01};
        vecs[6]  = '{2'b11, 27'd14, 27'd24, 1'b0, 2'b00, 1'b1, 27'd13, 2'b01};
        vecs[7]  = '{2'b11, 27'd14, 27'd24, 1'b0, 2'b00, 1'b1, 27'd13, 2'b01};
        vecs[8]  = '{2'b11, 27'd14, 27'd24, 1'b0, 2'b00, 1'b1, 27'd13, 2'b01};
        vecs[9]  = '{2'b11, 27'd14, 27'd24, 1'b1, 2'b10, 1'b1, 27'd24, 2'b10};
        vecs[10] = '{2'b10, 27'd0,  27'd30, 1'b1, 2'b10, 1'b1, 27'd30, 2'b10};
        vecs[11] = '{2'b10, 27'd0,  27'd31, 1'b1, 2'b10, 1'b1, 27'd31, 2'b10};
        vecs[12] = '{2'b00, 27'd0,  27'd0,  1'b1, 2'b00, 1'b0, 27'd0,  2'b00};
        vecs[13] = '{2'b01, 27'd40, 27'd0,  1'b0, 2'b01, 1'b1, 27'd40, 2'b01};
        vecs[14] = '{2'b00, 27'd0,  27'd0,  1'b0, 2'b00, 1'b1, 27'd40, 2'b01};
        vecs[15] = '{2'b00, 27'd0,  27'd0,  1'b1, 2'b00, 1'b0, 27'd0,  2'b00};

        // reset state
        drive(2'b11, 27'd1, 27'd2, 1'b1);
        #1;
        chk("rst_fb_valid", 64'(bus.fb_valid_out), 64'(0));
        chk("rst_fb_addr", 64'(bus.fb_addr_out), 64'(0));
        chk("rst_fb_last", 64'(bus.fb_last_out), 64'(0));
        chk("rst_ready", 64'(bus.req_ready_out), 64'(0));
        chk("rst_grant", 64'(grant_out), 64'(0));
        chk("rst_clearing", 64'(clearing_out), 64'(0));
        chk("rst_clear_done", 64'(clear_done_out), 64'(0));
        @(negedge clk_in);
        drive(2'b00, 27'd0, 27'd0, 1'b1);
        rst_in = 1'b0;

        // arbitration / backpressure table
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_in);
            drive(vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].rdy);
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(bus.req_ready_out), 64'(vecs[i].exp_ready));
            @(posedge clk_in);
            #1;
            chk($sformatf("vec%0d_fbv", i), 64'(bus.fb_valid_out), 64'(vecs[i].exp_fbv));
            chk($sformatf("vec%0d_grant", i), 64'(grant_out), 64'(vecs[i].exp_grant));
            if (vecs[i].exp_fbv) begin
                src = vecs[i].exp_grant[1] ? 1 : 0;
                chk($sformatf("vec%0d_addr", i), 64'(bus.fb_addr_out), 64'(vecs[i].exp_addr));
                chk($sformatf("vec%0d_color", i), 64'(bus.fb_color_out), 64'(rcolor(src, vecs[i].exp_addr)));
                chk($sformatf("vec%0d_depth", i), 64'(bus.fb_depth_out), 64'(rdepth(src, vecs[i].exp_addr)));
            end
        end

        // full clear sweep; clear coincides with a valid request
        @(negedge clk_in);
        drive(2'b01, 27'd50, 27'd0, 1'b1);
        @(negedge clk_in);
        drive(2'b01, 27'd51, 27'd0, 1'b1);
        clear_in = 1'b1;
        clear_color_in = 16'h8410;
        #1;
        chk("clr_accept_ready", 64'(bus.req_ready_out), 64'(0));
        chk("clr_accept_fb_addr", 64'(bus.fb_addr_out), 64'(50));
        chk("clr_accept_grant", 64'(grant_out), 64'(1));

        next_exp = 0; seq_err = 0; last_cnt = 0; rdy_viol = 0; clr_viol = 0; done_cnt = 0;
        for (int cyc = 0; cyc < 62000; cyc++) begin
            @(negedge clk_in);
            clear_color_in = 16'h0000;
            clear_in = (next_exp == 3000) ? 1'b1 : 1'b0;
            if (next_exp < 2000 || next_exp > 55600)
                bus.fb_ready_in = ($urandom_range(0, 3) != 0);
            else
                bus.fb_ready_in = 1'b1;
            #1;
            if (clear_done_out) begin
                done_cnt++;
                break;
            end
            if (bus.req_ready_out != 2'b00) rdy_viol++;
            if (!clearing_out) clr_viol++;
            if (bus.fb_valid_out && bus.fb_ready_in) begin
                if (bus.fb_addr_out != 27'(next_exp) || bus.fb_color_out != 16'h8410 ||
                    bus.fb_depth_out != 19'h7FFFF || grant_out != 2'b00 ||
                    bus.fb_last_out != (next_exp == 57599))
                    seq_err++;
                if (bus.fb_last_out) last_cnt++;
                next_exp++;
            end
        end
        clear_in = 1'b0;
        chk("sweep_done_pulse", 64'(done_cnt), 64'(1));
        chk("sweep_beats", 64'(next_exp), 64'(57600));
        chk("sweep_seq_errors", 64'(seq_err), 64'(0));
        chk("sweep_last_count", 64'(last_cnt), 64'(1));
        chk("sweep_ready_seen", 64'(rdy_viol), 64'(0));
        chk("sweep_clearing_low", 64'(clr_viol), 64'(0));
        chk("post_clear_ready", 64'(bus.req_ready_out), 64'(1));
        chk("post_clear_clearing", 64'(clearing_out), 64'(0));
        @(negedge clk_in);
        drive(2'b00, 27'd0, 27'd0, 1'b1);
        #1;
        chk("done_one_cycle", 64'(clear_done_out), 64'(0));
        chk("post_clear_fbv", 64'(bus.fb_valid_out), 64'(1));
        chk("post_clear_addr", 64'(bus.fb_addr_out), 64'(51));
        chk("post_clear_grant", 64'(grant_out), 64'(1));

        // held beat drains before the sweep; then reset aborts at addr 1000
        @(negedge clk_in);
        drive(2'b01, 27'd55, 27'd0, 1'b1);
        @(negedge clk_in);
        drive(2'b00, 27'd0, 27'd0, 1'b0);
        clear_in = 1'b1;
        clear_color_in = 16'h1234;
        #1;
        chk("held_fbv", 64'(bus.fb_valid_out), 64'(1));
        @(negedge clk_in);
        clear_in = 1'b0;
        bus.fb_ready_in = 1'b1;
        #1;
        chk("held_clearing", 64'(clearing_out), 64'(1));
        chk("held_addr", 64'(bus.fb_addr_out), 64'(55));
        chk("held_grant", 64'(grant_out), 64'(1));
        chk("held_fbv2", 64'(bus.fb_valid_out), 64'(1));
        @(negedge clk_in);
        #1;
        chk("first_clear_addr", 64'(bus.fb_addr_out), 64'(0));
        chk("first_clear_color", 64'(bus.fb_color_out), 64'(16'h1234));
        found = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_in);
            #1;
            if (bus.fb_valid_out && bus.fb_addr_out == 27'd1000) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reached_1000", 64'(found), 64'(1));
        #2;
        rst_in = 1'b1;
        drive(2'b11, 27'd60, 27'd70, 1'b1);
        #1;
        chk("abort_fbv", 64'(bus.fb_valid_out), 64'(0));
        chk("abort_addr", 64'(bus.fb_addr_out), 64'(0));
        chk("abort_color", 64'(bus.fb_color_out), 64'(0));
        chk("abort_depth", 64'(bus.fb_depth_out), 64'(0));
        chk("abort_clearing", 64'(clearing_out), 64'(0));
        chk("abort_ready", 64'(bus.req_ready_out), 64'(0));
        chk("abort_done", 64'(clear_done_out), 64'(0));
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        chk("resume_ready", 64'(bus.req_ready_out), 64'(1));
        @(negedge clk_in);
        #1;
        chk("resume_addr", 64'(bus.fb_addr_out), 64'(60));
        chk("resume_grant", 64'(grant_out), 64'(1));
        chk("resume_no_done", 64'(clear_done_out), 64'(0));
        chk("resume_ready2", 64'(bus.req_ready_out), 64'(2));
        @(negedge clk_in);
        drive(2'b00, 27'd0, 27'd0, 1'b1);
        #1;
        chk("resume_addr2", 64'(bus.fb_addr_out), 64'(70));
        chk("resume_grant2", 64'(grant_out), 64'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
Sequences all writes into the framebuffer's single write port (valid/ready with addr, color and depth). It shares that port between two pixel requesters, the rasterizer and the test-pattern source, using round-robin arbitration. It also contains a clear sequencer that sweeps the whole HRES*VRES frame with a clear color and maximum depth. It sits between the graphics sources and the framebuffer, in the framebuffer write clock domain.

Parameters:
HRES, 320, frame width in pixels
VRES, 180, frame height in pixels
Z_WIDTH, 19, depth field width
ADDR_WIDTH, 27, pixel address width
ADDR_MAX, HRES*VRES, number of pixels swept by a clear (derived)

Ports:
clk_in  input  1  write-domain clock
rst_in  input  1  reset; asynchronous, active-high
clear_in  input  1  single-cycle clear request
clear_color_in  input  16  RGB565 clear color, latched on clear acceptance
req_valid_in  input  2  per-requester valid; [0]=rasterizer, [1]=pattern
req_addr_in  input  2x27  per-requester address
req_color_in  input  2x16  per-requester color
req_depth_in  input  2x19  per-requester depth
req_ready_out  output  2  per-requester ready
fb_valid_out  output  1  write valid to framebuffer
fb_ready_in  input  1  framebuffer ready
fb_addr_out  output  27  write address
fb_color_out  output  16  write color
fb_depth_out  output  19  write depth
fb_last_out  output  1  marks final write of a clear sweep
grant_out  output  2  one-hot source of the current fb_* beat (00 while clearing or idle)
clearing_out  output  1  high while in CLEAR
clear_done_out  output  1  one-cycle pulse when the last clear beat is accepted

Behaviour:
- Reset (async, rst_in=1): state=ARB; fb_valid_out=0; all fb_* data=0; fb_last_out=0; req_ready_out=0; grant_out=0; clearing_out=0; clear_done_out=0; clear counter=0; clear_pending=0; round-robin pointer=0 (rasterizer first).
- Output stage:
  - One register stage. load = !fb_valid_out || fb_ready_in.
  - fb_* hold stable while fb_valid_out && !fb_ready_in.
  - Latency from a requester handshake to fb_valid_out is 1 cycle.
- States: ARB, CLEAR.
- ARB:
  - Arbitration is combinational over req_valid_in, with pointer priority.
  - req_ready_out[i] = load && !clear_pending && winner==i. At most one bit is ever high.
  - A requester transfers when req_valid_in[i] && req_ready_out[i]. On transfer, fb_* load that requester's fields, grant_out=onehot(i), and the pointer moves to the other requester.
  - If only one requester is valid, it wins every cycle (no bubbles).
  - On load with no transfer, fb_valid_out=0.
- Clear acceptance:
  - clear_in in ARB sets clear_pending and latches clear_color_in.
  - In the same cycle, req_ready_out is forced to 0.
  - Next cycle: state=CLEAR, counter=0.
- CLEAR:
  - On each load, issue addr=counter, color=latched clear color, depth=all ones, grant_out=0.
  - The counter increments on each load.
  - The beat with counter==ADDR_MAX-1 carries fb_last_out=1.
  - When that beat's handshake completes (fb_valid_out && fb_ready_in && fb_last_out): clear_done_out=1 for one cycle, state=ARB, clear_pending=0.
  - clearing_out=1 throughout CLEAR.
  - req_ready_out=0 throughout CLEAR.
- clear_in while in CLEAR or while clear_pending is set is ignored; it neither restarts nor queues a clear.
- clear_in coinciding with a requester valid: clear wins, and the requester is not granted that cycle.
- A beat already in the output register when a clear is accepted completes normally before the first clear beat.
- The counter width is $clog2(ADDR_MAX). It never wraps, because CLEAR exits at ADDR_MAX-1.
- Addresses from requesters are passed through unmodified; they are not range-checked.
- Reset asserted mid-CLEAR aborts the sweep immediately, with no clear_done_out pulse.

Decomposition:
- Shared package (fb_pkg): FB_ADDR_WIDTH=27, FB_COLOR_WIDTH=16, FB_Z_WIDTH=19, a typedef fb_write_t {addr, color, depth}, and the state enum {ARB, CLEAR}.
- One natural sub-module: rr_arbiter2. It holds the 2-way round-robin winner and pointer, taking valid, advance and rst_in/clk_in.

Test Plan:
- Reset then idle: all outputs 0; raising req_valid_in=01 with addr=5 and fb_ready_in=1 -> req_ready_out=01 the same cycle; next cycle fb_valid_out=1, fb_addr_out=5, grant_out=01.
- Both requesters valid continuously with fb_ready_in=1 -> grants alternate 01,10,01,10 and four beats are delivered in four consecutive cycles.
- fb_ready_in low for 3 cycles while fb_valid_out=1 -> fb_* held constant; req_ready_out=00; the transfer resumes the cycle fb_ready_in rises.
- clear_in with color 16'h8410, fb_ready_in=1 -> 57600 beats with addr 0..57599, depth 19'h7FFFF; fb_last_out only on addr 57599; one clear_done_out pulse; no req_ready_out during the sweep.
- Second clear_in mid-sweep plus random fb_ready_in backpressure -> exactly one sweep and no skipped or duplicated addresses.
- rst_in asserted at sweep addr 1000 -> outputs 0 asynchronously; no clear_done_out; after release, arbitration resumes with the rasterizer first.
